// File: rtl/p2s_buf.sv
// Parallel-to-serial converter: N-bit words out as N/W beats of W bits, with a one-word hold buffer.
// Latency 1 cycle to first beat; p_ready = !hold_valid, and s_ready low freezes the current beat.
module p2s_buf #(
    parameter int N         = 8,
    parameter int W         = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         p_valid,
    input  logic [N-1:0] p_data,
    output logic         p_ready,
    output logic [W-1:0] s_data,
    output logic         s_valid,
    input  logic         s_ready,
    output logic         s_last
);

    localparam int B  = N / W;
    localparam int CW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    generate
        if (N % W != 0) begin : g_bad_width
            $error("p2s_buf: N must be a multiple of W");
        end
    endgenerate

    logic [N-1:0]  shreg;
    logic [N-1:0]  hold_data;
    logic          active_valid;
    logic          hold_valid;
    logic [CW-1:0] count;
    logic          p_fire;
    logic          s_fire;
    logic          reload;

    assign p_ready = !hold_valid;
    assign s_valid = active_valid;
    assign s_last  = active_valid && (count == LAST);
    assign s_data  = MSB_FIRST ? shreg[N-1 -: W] : shreg[W-1:0];

    assign p_fire  = p_valid && p_ready;
    assign s_fire  = s_valid && s_ready;
    // Active stage is free this edge: either empty or its final beat is leaving.
    assign reload  = !active_valid || (s_fire && s_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg        <= '0;
            hold_data    <= '0;
            active_valid <= 1'b0;
            hold_valid   <= 1'b0;
            count        <= '0;
        end else if (reload) begin
            count <= '0;
            // p_fire cannot coincide with hold_valid, so the held word never loses its turn.
            if (hold_valid) begin
                shreg        <= hold_data;
                active_valid <= 1'b1;
                hold_valid   <= 1'b0;
            end else if (p_fire) begin
                shreg        <= p_data;
                active_valid <= 1'b1;
            end else begin
                active_valid <= 1'b0;
            end
        end else begin
            if (s_fire) begin
                shreg <= MSB_FIRST ? (shreg << W) : (shreg >> W);
                count <= count + CW'(1);
            end
            if (p_fire) begin
                hold_data  <= p_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p2s_buf.sv
// Directed bench for p2s_buf: LSB-first and MSB-first W=2 instances plus a W=N instance share one stimulus.
module tb_p2s_buf;

    logic       clk = 1'b0;
    logic       rstn;
    logic       p_valid;
    logic [7:0] p_data;
    logic       s_ready;

    logic       l_p_ready, l_s_valid, l_s_last;
    logic [1:0] l_s_data;
    logic       m_p_ready, m_s_valid, m_s_last;
    logic [1:0] m_s_data;
    logic       w_p_ready, w_s_valid, w_s_last;
    logic [7:0] w_s_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    p2s_buf #(.N(8), .W(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstn(rstn), .p_valid(p_valid), .p_data(p_data), .p_ready(l_p_ready),
        .s_data(l_s_data), .s_valid(l_s_valid), .s_ready(s_ready), .s_last(l_s_last));

    p2s_buf #(.N(8), .W(2), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstn(rstn), .p_valid(p_valid), .p_data(p_data), .p_ready(m_p_ready),
        .s_data(m_s_data), .s_valid(m_s_valid), .s_ready(s_ready), .s_last(m_s_last));

    p2s_buf #(.N(8), .W(8), .MSB_FIRST(1'b0)) u_w8 (
        .clk(clk), .rstn(rstn), .p_valid(p_valid), .p_data(p_data), .p_ready(w_p_ready),
        .s_data(w_s_data), .s_valid(w_s_valid), .s_ready(s_ready), .s_last(w_s_last));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        p_valid = 1'b0;
        s_ready = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; p_valid = 1'b0; p_data = 8'h00; s_ready = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        total++; if ({l_p_ready, l_s_valid, l_s_last, l_s_data} !== 5'b10000) begin bad++;
            $display("FAIL reset_lsb: got %b expected 10000", {l_p_ready, l_s_valid, l_s_last, l_s_data}); end
        total++; if ({m_p_ready, m_s_valid, m_s_last, m_s_data} !== 5'b10000) begin bad++;
            $display("FAIL reset_msb: got %b expected 10000", {m_p_ready, m_s_valid, m_s_last, m_s_data}); end
        total++; if ({w_p_ready, w_s_valid, w_s_last, w_s_data} !== 11'b100_0000_0000) begin bad++;
            $display("FAIL reset_w8: got %b expected 10000000000", {w_p_ready, w_s_valid, w_s_last, w_s_data}); end
    endtask

    task automatic test_single();
        logic [1:0] exp_l [4];
        logic [1:0] exp_m [4];
        exp_l = '{2'd0, 2'd1, 2'd3, 2'd2};
        exp_m = '{2'd2, 2'd3, 2'd1, 2'd0};
        p_valid = 1'b1; p_data = 8'hB4; s_ready = 1'b1;
        tick();
        p_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if ({l_s_valid, l_s_last, l_s_data} !== {1'b1, i == 3, exp_l[i]}) begin bad++;
                $display("FAIL single_lsb beat %0d: got v/l/d %b expected %b", i,
                         {l_s_valid, l_s_last, l_s_data}, {1'b1, i == 3, exp_l[i]}); end
            total++; if ({m_s_valid, m_s_last, m_s_data} !== {1'b1, i == 3, exp_m[i]}) begin bad++;
                $display("FAIL single_msb beat %0d: got v/l/d %b expected %b", i,
                         {m_s_valid, m_s_last, m_s_data}, {1'b1, i == 3, exp_m[i]}); end
            tick();
        end
        total++; if (l_s_valid !== 1'b0 || m_s_valid !== 1'b0) begin bad++;
            $display("FAIL single_idle: got s_valid lsb=%b msb=%b expected 0", l_s_valid, m_s_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_d [8];
        exp_d = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        p_valid = 1'b1; p_data = 8'hB4; s_ready = 1'b1;
        tick();
        p_data = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            total++; if ({l_s_valid, l_s_last, l_s_data} !== {1'b1, (i == 3) || (i == 7), exp_d[i]}) begin bad++;
                $display("FAIL b2b beat %0d: got v/l/d %b expected %b", i,
                         {l_s_valid, l_s_last, l_s_data}, {1'b1, (i == 3) || (i == 7), exp_d[i]}); end
            if (i == 1) begin
                total++; if (l_p_ready !== 1'b0) begin bad++;
                    $display("FAIL b2b_hold_full: got p_ready %b expected 0", l_p_ready); end
            end
            if (i == 4) begin
                total++; if (l_p_ready !== 1'b1) begin bad++;
                    $display("FAIL b2b_hold_drained: got p_ready %b expected 1", l_p_ready); end
            end
            if (i == 0) p_valid = 1'b1;
            else p_valid = 1'b0;
            tick();
        end
        total++; if (l_s_valid !== 1'b0) begin bad++;
            $display("FAIL b2b_idle: got s_valid %b expected 0", l_s_valid); end
        drain();
    endtask

    task automatic test_stall();
        logic [1:0] exp_d [15];
        logic       exp_r [15];
        logic       exp_s [15];
        exp_d = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        p_valid = 1'b1; p_data = 8'hB4; s_ready = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            total++; if ({l_s_valid, l_s_last, l_s_data, l_p_ready} !==
                         {1'b1, exp_s[i-1], exp_d[i-1], exp_r[i-1]}) begin bad++;
                $display("FAIL stall cycle %0d: got v/l/d/pr %b expected %b", i,
                         {l_s_valid, l_s_last, l_s_data, l_p_ready}, {1'b1, exp_s[i-1], exp_d[i-1], exp_r[i-1]}); end
            s_ready = !(i >= 2 && i <= 4);
            p_valid = (i <= 8);
            p_data  = (i == 1) ? 8'h5A : 8'hC3;
            tick();
        end
        total++; if (l_s_valid !== 1'b0) begin bad++;
            $display("FAIL stall_idle: got s_valid %b expected 0", l_s_valid); end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_d [4];
        exp_d = '{2'd2, 2'd2, 2'd1, 2'd1};
        p_valid = 1'b1; p_data = 8'hB4; s_ready = 1'b1;
        tick();
        p_data = 8'hC3;
        tick();
        p_valid = 1'b0;
        total++; if (l_p_ready !== 1'b0) begin bad++;
            $display("FAIL rmid_held: got p_ready %b expected 0", l_p_ready); end
        tick();
        total++; if (l_s_data !== 2'd3) begin bad++;
            $display("FAIL rmid_beat3: got s_data %0d expected 3", l_s_data); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++; if ({l_s_valid, l_p_ready, l_s_last, l_s_data} !== 5'b01000) begin bad++;
            $display("FAIL rmid_after_reset: got v/pr/l/d %b expected 01000", {l_s_valid, l_p_ready, l_s_last, l_s_data}); end
        p_valid = 1'b1; p_data = 8'h5A;
        tick();
        p_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if ({l_s_valid, l_s_last, l_s_data} !== {1'b1, i == 3, exp_d[i]}) begin bad++;
                $display("FAIL rmid_next beat %0d: got v/l/d %b expected %b", i,
                         {l_s_valid, l_s_last, l_s_data}, {1'b1, i == 3, exp_d[i]}); end
            tick();
        end
        total++; if (l_s_valid !== 1'b0) begin bad++;
            $display("FAIL rmid_no_stale: got s_valid %b expected 0", l_s_valid); end
        drain();
    endtask

    task automatic test_single_beat();
        logic [7:0] words [3];
        words = '{8'hA5, 8'h3C, 8'hFF};
        p_valid = 1'b1; p_data = words[0]; s_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if ({w_s_valid, w_s_last, w_s_data} !== {2'b11, words[i]}) begin bad++;
                $display("FAIL w8 word %0d: got v/l/d %b expected %b", i,
                         {w_s_valid, w_s_last, w_s_data}, {2'b11, words[i]}); end
            p_valid = (i < 2);
            p_data  = (i < 2) ? words[i+1] : 8'h00;
            tick();
        end
        total++; if (w_s_valid !== 1'b0) begin bad++;
            $display("FAIL w8_idle: got s_valid %b expected 0", w_s_valid); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_single_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p2s_buf.md
P2S_BUF -- requirements
Module: p2s_buf

Interface
REQ-001 SHALL have parameter N, default 8, meaning parallel word width in bits.
REQ-002 SHALL have parameter W, default 1, meaning serial lane width in bits per beat; N mod W = 0, else elaboration error.
REQ-003 SHALL have parameter MSB_FIRST, default 0, where 0 sends the LSB lane first and 1 sends the MSB lane first.
REQ-004 SHALL define B = N/W beats per word and a beat counter of width max(1,$clog2(B)).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port p_valid, input, 1 bit: parallel word offered.
REQ-008 SHALL have port p_data, input, N bits: parallel word.
REQ-009 SHALL have port p_ready, output, 1 bit: block can accept a word this cycle.
REQ-010 SHALL have port s_data, output, W bits: current serial beat.
REQ-011 SHALL have port s_valid, output, 1 bit: s_data is valid.
REQ-012 SHALL have port s_ready, input, 1 bit: sink accepts the beat.
REQ-013 SHALL have port s_last, output, 1 bit: current beat is the final beat of its word.

Function
REQ-014 SHALL define p_fire = p_valid & p_ready and s_fire = s_valid & s_ready; transfers occur only on fire.
REQ-015 SHALL hold two storage stages: an active shift register (shreg, active_valid, count) and a one-word hold buffer (hold_data, hold_valid).
REQ-016 SHALL drive p_ready = !hold_valid combinationally, independent of p_valid and s_ready.
REQ-017 SHALL drive s_valid = active_valid, and s_last = active_valid & (count == B-1).
REQ-018 SHALL drive s_data = shreg[W-1:0] when MSB_FIRST=0, and s_data = shreg[N-1:N-W] when MSB_FIRST=1.
REQ-019 SHALL, when active_valid=0 or (s_fire & s_last), reload with priority: hold_data if hold_valid (then clear hold_valid); else p_data if p_fire; else clear active_valid; count <= 0 on any reload.
REQ-020 SHALL, on s_fire & !s_last, shift shreg by W toward the output lane (right for MSB_FIRST=0, left for 1), zero-filling, and increment count.
REQ-021 SHALL, when active_valid=1 and no reload occurs, write p_data into hold and set hold_valid on p_fire.
REQ-022 SHALL hold shreg, count, s_data and s_last stable while s_valid=1 & s_ready=0.
REQ-023 SHALL give first-beat latency of 1 cycle: a word accepted at edge k with the active stage empty appears on s_data after edge k.
REQ-024 SHALL, with s_ready=1 and words continuously available, output beats with no idle cycle between words (full throughput, B cycles per word).
REQ-025 SHALL, when B=1 (W=N), assert s_last on every valid beat and reload every s_fire.
REQ-026 SHALL ensure s_valid never deasserts without s_fire, and never drops or duplicates a word or beat.
REQ-027 SHALL ensure the count never exceeds B-1 and wraps to 0 only via reload.

Reset
REQ-028 SHALL, while rstn=0 at a rising edge, clear active_valid, hold_valid, count, shreg and hold_data to 0.
REQ-029 SHALL produce post-reset outputs p_ready=1, s_valid=0, s_last=0, s_data=0.
REQ-030 SHALL discard any in-flight word, active or held, on reset mid-operation, with no partial beats afterwards.

Verification
REQ-031 SHALL verify N=8, W=2, MSB_FIRST=0, s_ready=1, p_data=8'hB4 accepted once -> s_data beats 0,1,3,2 on consecutive cycles, s_last only on beat 4, then s_valid=0.
REQ-032 SHALL verify the same stimulus with MSB_FIRST=1 -> beats 2,3,1,0.
REQ-033 SHALL verify back-to-back 8'hB4 then 8'h5A (W=2, LSB-first) -> 8 consecutive beats 0,1,3,2,2,2,1,1 with no gap and s_last on beats 4 and 8.
REQ-034 SHALL verify s_ready=0 for 3 cycles during beat 2 while offering words continuously -> s_data holds 1; the second word enters hold; p_ready=0 until the hold buffer drains; no beat is lost.
REQ-035 SHALL verify rstn=0 for one edge during beat 3 -> next cycle s_valid=0, p_ready=1, s_data=0, and the next word starts at beat 1.
REQ-036 SHALL verify N=8, W=8 -> each accepted word is one beat equal to p_data, with s_last=1 on every beat.
